// File: rtl/pixie_dma_ctrl.sv
// Pixie-style display DMA front end: line/frame timing, DMAO/INT/EFx, and framebuffer capture of DMA bytes.
// Build macro PIXIE_DMA_STATS_EN adds the dma_short / dma_frames statistics outputs.
module pixie_dma_ctrl #(
    parameter int BYTES_PER_LINE    = 14,
    parameter int LINES_PER_FRAME   = 262,
    parameter int DMA_BYTES         = 8,
    parameter int FIRST_ACTIVE_LINE = 80,
    parameter int ACTIVE_LINES      = 128,
    parameter int INT_LEAD          = 2,
    parameter int EF_LEAD           = 4,
    parameter int ADDR_W            = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [1:0]        SC,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [1:0]        line_repeat,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        data_in,
    output logic              DMAO,
    output logic              INT,
    output logic              EFx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en,
    output logic              line_start,
`ifdef PIXIE_DMA_STATS_EN
    output logic              frame_start,
    output logic              dma_short,
    output logic [7:0]        dma_frames
`else
    output logic              frame_start
`endif
);
    localparam int H_W = $clog2(BYTES_PER_LINE);
    localparam int V_W = $clog2(LINES_PER_FRAME);
    localparam int X_W = $clog2(DMA_BYTES + 1);
    localparam int LAST_ACTIVE = FIRST_ACTIVE_LINE + ACTIVE_LINES - 1;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [H_W-1:0]    h_cnt_reg, h_next;
    logic [V_W-1:0]    v_cnt_reg, v_next;
    logic              enabled_reg, enabled_next;
    logic [ADDR_W-1:0] addr_cnt_reg, addr_next, addr_step;
    logic [ADDR_W-1:0] row_start_reg, row_next;
    logic [2:0]        rep_cnt_reg, rep_next, rep_limit;
    logic [1:0]        rep_sel_reg, rep_sel_next;
    logic [X_W-1:0]    xfer_cnt_reg, xfer_next, xfer_step;

    logic              dmao_reg, int_reg, efx_reg, wr_en_reg, line_start_reg, frame_start_reg;
    logic              dmao_next, int_next, efx_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_data_reg;

    logic h_wrap, v_wrap, active, dma_hit;

    always_comb begin
        h_wrap    = (h_cnt_reg == H_W'(BYTES_PER_LINE - 1));
        v_wrap    = h_wrap && (v_cnt_reg == V_W'(LINES_PER_FRAME - 1));
        active    = in_range(int'(v_cnt_reg), FIRST_ACTIVE_LINE, LAST_ACTIVE);
        dma_hit   = (SC == 2'b10) && enabled_reg && active && (xfer_cnt_reg < X_W'(DMA_BYTES));
        // repeat-1 for the 1/2/4/8 modes
        rep_limit = {rep_sel_reg == 2'b11, rep_sel_reg[1], |rep_sel_reg};
        addr_step = addr_cnt_reg + ADDR_W'(dma_hit);
        xfer_step = xfer_cnt_reg + X_W'(dma_hit);

        h_next       = h_wrap ? '0 : h_cnt_reg + H_W'(1);
        v_next       = v_cnt_reg;
        addr_next    = addr_step;
        row_next     = row_start_reg;
        rep_next     = rep_cnt_reg;
        rep_sel_next = rep_sel_reg;
        xfer_next    = xfer_step;

        if (h_wrap) begin
            v_next    = v_wrap ? '0 : v_cnt_reg + V_W'(1);
            xfer_next = '0;
            if (active) begin
                if (rep_cnt_reg < rep_limit) begin
                    rep_next  = rep_cnt_reg + 3'd1;
                    addr_next = row_start_reg;
                end else begin
                    rep_next = 3'd0;
                    row_next = addr_step;
                end
            end
        end
        if (v_wrap) begin
            rep_sel_next = line_repeat;
            addr_next    = base_addr;
            row_next     = base_addr;
            rep_next     = 3'd0;
        end

        enabled_next = disp_off ? 1'b0 : (disp_on ? 1'b1 : enabled_reg);

        // Output flags describe the counter state that holds after this machine cycle.
        dmao_next = !(enabled_next && in_range(int'(v_next), FIRST_ACTIVE_LINE, LAST_ACTIVE)
                      && in_range(int'(h_next), 1, DMA_BYTES));
        int_next  = enabled_next && in_range(int'(v_next), FIRST_ACTIVE_LINE - INT_LEAD,
                                             FIRST_ACTIVE_LINE - 1);
        efx_next  = !(in_range(int'(v_next), FIRST_ACTIVE_LINE - EF_LEAD, FIRST_ACTIVE_LINE - 1)
                      || in_range(int'(v_next), LAST_ACTIVE - EF_LEAD + 1, LAST_ACTIVE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            enabled_reg     <= 1'b0;
            addr_cnt_reg    <= '0;
            row_start_reg   <= '0;
            rep_cnt_reg     <= 3'd0;
            rep_sel_reg     <= 2'b00;
            xfer_cnt_reg    <= '0;
            dmao_reg        <= 1'b1;
            int_reg         <= 1'b0;
            efx_reg         <= 1'b1;
            wr_en_reg       <= 1'b0;
            mem_addr_reg    <= '0;
            mem_data_reg    <= 8'd0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            wr_en_reg       <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            if (clk_enable) begin
                h_cnt_reg       <= h_next;
                v_cnt_reg       <= v_next;
                enabled_reg     <= enabled_next;
                addr_cnt_reg    <= addr_next;
                row_start_reg   <= row_next;
                rep_cnt_reg     <= rep_next;
                rep_sel_reg     <= rep_sel_next;
                xfer_cnt_reg    <= xfer_next;
                dmao_reg        <= dmao_next;
                int_reg         <= int_next;
                efx_reg         <= efx_next;
                wr_en_reg       <= dma_hit;
                line_start_reg  <= h_wrap;
                frame_start_reg <= v_wrap;
                if (dma_hit) begin
                    mem_addr_reg <= addr_cnt_reg;
                    mem_data_reg <= data_in;
                end
            end
        end
    end

    assign DMAO        = dmao_reg;
    assign INT         = int_reg;
    assign EFx         = efx_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_data    = mem_data_reg;
    assign mem_wr_en   = wr_en_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

`ifdef PIXIE_DMA_STATS_EN
    logic       dma_short_reg;
    logic [7:0] dma_frames_reg;
    logic       short_line;

    assign short_line = h_wrap && active && (xfer_step != '0) && (xfer_step < X_W'(DMA_BYTES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_short_reg  <= 1'b0;
            dma_frames_reg <= 8'd0;
        end else if (clk_enable) begin
            if (disp_on)
                dma_short_reg <= 1'b0;
            else if (short_line)
                dma_short_reg <= 1'b1;
            if (v_wrap && enabled_reg)
                dma_frames_reg <= dma_frames_reg + 8'd1;
        end
    end

    assign dma_short  = dma_short_reg;
    assign dma_frames = dma_frames_reg;
`endif
endmodule

// File: tb/tb_pixie_dma_ctrl.sv
// Randomised bench for pixie_dma_ctrl: a machine-cycle-indexed reference model checked every clk,
// plus literal per-frame totals (write counts, address spans, INT/EFx durations).
module tb_pixie_dma_ctrl;
    localparam int BPL = 14, LPF = 262, NDMA = 8, FAL = 80, NACT = 128;
    localparam int INT_LEAD = 2, EF_LEAD = 4, AW = 10;
    localparam int FRAME_MC = BPL * LPF;

    logic          clk = 1'b0, rst = 1'b1, ce = 1'b0;
    logic [1:0]    sc = 2'b00, lrep = 2'b00;
    logic          on = 1'b0, off = 1'b0;
    logic [AW-1:0] base = '0;
    logic [7:0]    din = 8'd0;
    logic          DMAO, INT, EFx, mem_wr_en, line_start, frame_start;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
`ifdef PIXIE_DMA_STATS_EN
    logic          dma_short;
    logic [7:0]    dma_frames;
`endif

    pixie_dma_ctrl dut (
        .clk(clk), .reset(rst), .clk_enable(ce), .SC(sc), .disp_on(on), .disp_off(off),
        .line_repeat(lrep), .base_addr(base), .data_in(din),
        .DMAO(DMAO), .INT(INT), .EFx(EFx), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr_en(mem_wr_en), .line_start(line_start),
`ifdef PIXIE_DMA_STATS_EN
        .frame_start(frame_start), .dma_short(dma_short), .dma_frames(dma_frames)
`else
        .frame_start(frame_start)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
        $display("[%0t] %s = 0x%0h (expect 0x%0h)", $time, name, act, exp);
    endtask

    // Reference model: timing derived from the count of machine cycles since reset
    int mc, m_addr, m_row, m_rep, m_rep_sel, m_xfer, m_end_row, m_frames;
    bit m_en, m_short;
    bit e_dmao, e_int, e_efx, e_wr, e_ls, e_fs;
    int e_addr, e_data;

    task automatic model_reset();
        mc = 0; m_addr = 0; m_row = 0; m_rep = 0; m_rep_sel = 0; m_xfer = 0;
        m_en = 0; m_short = 0; m_frames = 0;
        e_dmao = 1; e_int = 0; e_efx = 1; e_wr = 0; e_ls = 0; e_fs = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic model_step();
        int h, v, h2, v2;
        bit act, wrap, hit;
        h = mc % BPL;
        v = (mc / BPL) % LPF;
        act  = (v >= FAL) && (v < FAL + NACT);
        wrap = (h == BPL - 1);
        hit  = (sc == 2'b10) && m_en && act && (m_xfer < NDMA);
        e_wr = hit;
        if (hit) begin
            e_addr = m_addr;
            e_data = din;
            m_addr = (m_addr + 1) % (1 << AW);
            m_xfer++;
        end
        e_ls = wrap;
        e_fs = wrap && (v == LPF - 1);
        if (wrap) begin
            if (act && m_xfer > 0 && m_xfer < NDMA) m_short = 1;
            m_xfer = 0;
            if (act) begin
                if (m_rep < (1 << m_rep_sel) - 1) begin
                    m_rep++;
                    m_addr = m_row;
                end else begin
                    m_rep = 0;
                    m_row = m_addr;
                end
            end
            if (v == FAL + NACT - 1) m_end_row = m_row;
            if (v == LPF - 1) begin
                if (m_en) m_frames = (m_frames + 1) % 256;
                m_rep_sel = lrep;
                m_addr = base;
                m_row = base;
                m_rep = 0;
            end
        end
        if (on) m_short = 0;
        if (off) m_en = 0;
        else if (on) m_en = 1;
        mc++;
        h2 = mc % BPL;
        v2 = (mc / BPL) % LPF;
        e_dmao = !(m_en && v2 >= FAL && v2 < FAL + NACT && h2 >= 1 && h2 <= NDMA);
        e_int  = m_en && v2 >= FAL - INT_LEAD && v2 < FAL;
        e_efx  = !((v2 >= FAL - EF_LEAD && v2 < FAL) || (v2 >= FAL + NACT - EF_LEAD && v2 < FAL + NACT));
    endtask

    // Per-window totals of DUT activity, sampled after each machine cycle
    int c_wr, c_first, c_last, c_int, c_efx;

    task automatic clear_counts();
        c_wr = 0; c_first = -1; c_last = -1; c_int = 0; c_efx = 0;
    endtask

    initial begin
        bit was_ce;
        model_reset();
        clear_counts();
        forever begin
            @(posedge clk);
            was_ce = 0;
            if (rst) model_reset();
            else if (ce) begin
                model_step();
                was_ce = 1;
            end else begin
                e_wr = 0; e_ls = 0; e_fs = 0;
            end
            #1;
            check("DMAO", DMAO, e_dmao);
            check("INT", INT, e_int);
            check("EFx", EFx, e_efx);
            check("mem_wr_en", mem_wr_en, e_wr);
            check("mem_addr", mem_addr, e_addr);
            check("mem_data", mem_data, e_data);
            check("line_start", line_start, e_ls);
            check("frame_start", frame_start, e_fs);
`ifdef PIXIE_DMA_STATS_EN
            check("dma_short", dma_short, m_short);
            check("dma_frames", dma_frames, m_frames);
`endif
            if (was_ce) begin
                if (mem_wr_en === 1'b1) begin
                    if (c_wr == 0) c_first = mem_addr;
                    c_last = mem_addr;
                    c_wr++;
                end
                if (INT === 1'b1) c_int++;
                if (EFx === 1'b0) c_efx++;
            end
        end
    end

    // Stimulus: mode 0 random SC, 1 DMA at h 1..8, 2 DMA at h 1..10, 3 random everything
    int mode = 0;
    bit pend_on = 0, pend_off = 0;

    task automatic mc_step();
        int h;
        @(negedge clk);
        h = mc % BPL;
        ce  = 1'b1;
        din = 8'($urandom);
        on  = pend_on;
        off = pend_off;
        pend_on = 0;
        pend_off = 0;
        case (mode)
            1: sc = (h >= 1 && h <= NDMA) ? 2'b10 : 2'b01;
            2: sc = (h >= 1 && h <= NDMA + 2) ? 2'b10 : 2'b01;
            3: begin
                sc = ($urandom_range(9) < 4) ? 2'b10 : 2'($urandom_range(3));
                if ($urandom_range(499) == 0) on = 1'b1;
                if ($urandom_range(1499) == 0) off = 1'b1;
                if ($urandom_range(199) == 0) lrep = 2'($urandom);
                if ($urandom_range(199) == 0) base = AW'($urandom);
            end
            default: sc = 2'($urandom_range(3));
        endcase
        @(negedge clk);
        ce  = 1'b0;
        on  = 1'b0;
        off = 1'b0;
        sc  = 2'($urandom);
        din = 8'($urandom);
    endtask

    task automatic run_frame();
        clear_counts();
        repeat (FRAME_MC) mc_step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pin("reset_DMAO", DMAO, 1);
        pin("reset_EFx", EFx, 1);
        pin("reset_INT", INT, 0);
        pin("reset_mem_wr_en", mem_wr_en, 0);
        @(negedge clk);
        rst = 1'b0;

        // Disabled then enabled, stop mid-frame at v_cnt=100, h_cnt=5
        mode = 1;
        clear_counts();
        repeat (30) mc_step();
        pin("disabled_writes", c_wr, 0);
        pend_on = 1;
        repeat (100 * BPL + 5 - 30) mc_step();
        pin("pre_reset_writes", c_wr, 164);
        pin("pre_reset_addr", mem_addr, 163);
        #2 rst = 1'b1;
        #1;
        pin("async_DMAO", DMAO, 1);
        pin("async_INT", INT, 0);
        pin("async_EFx", EFx, 1);
        pin("async_mem_wr_en", mem_wr_en, 0);
        pin("async_mem_addr", mem_addr, 0);
        pin("async_mem_data", mem_data, 0);
        pin("async_line_start", line_start, 0);
        pin("async_frame_start", frame_start, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Frame A1: full DMA, repeat 1, base 0 from reset
        pend_on = 1;
        lrep = 2'b00;
        base = AW'(10'h040);
        mode = 1;
        run_frame();
        pin("A1_writes", c_wr, 1024);
        pin("A1_first_addr", c_first, 0);
        pin("A1_last_addr", c_last, 10'h3FF);
        pin("A1_int_cycles", c_int, 2 * BPL);
        pin("A1_efx_cycles", c_efx, 8 * BPL);

        // Frame A2: extra DMA cycles per line are ignored, base 0x040
        mode = 2;
        lrep = 2'b10;
        base = AW'(10'h100);
        run_frame();
        pin("A2_writes", c_wr, 1024);
        pin("A2_first_addr", c_first, 10'h040);
        pin("A2_last_addr", c_last, 10'h03F);

        // Frame B: 4 lines per row from 0x100
        mode = 1;
        run_frame();
        pin("B_writes", c_wr, 1024);
        pin("B_first_addr", c_first, 10'h100);
        pin("B_last_addr", c_last, 10'h1FF);
        pin("B_model_row_end", m_end_row, 10'h200);
`ifdef PIXIE_DMA_STATS_EN
        pin("B_dma_frames", dma_frames, 3);
        pin("B_dma_short", dma_short, 0);
`endif

        // Frame C: simultaneous on/off leaves display disabled
        pend_on = 1;
        pend_off = 1;
        mode = 0;
        run_frame();
        pin("C_writes", c_wr, 0);
        pin("C_int_cycles", c_int, 0);
        pin("C_efx_cycles", c_efx, 8 * BPL);

        // Randomised frames
        pend_on = 1;
        mode = 3;
        repeat (2) run_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pixie_dma_ctrl.md
Name: pixie_dma_ctrl

Overview:
- Parametrised successor to the CDP1861-style Pixie frontend: generates line/frame timing, DMA requests, interrupt and EF flag from the CPU machine-cycle strobe.
- Captures DMA bytes into the display framebuffer at an internally generated address.
- Adds programmable line repeat (vertical resolution modes), a programmable base address and configurable geometry.
- Sits between the 1802 core (SC/DMA/INT/EF) and the framebuffer RAM that the video backend reads.

Parameters:
- BYTES_PER_LINE, 14, machine cycles per scan line.
- LINES_PER_FRAME, 262, scan lines per frame.
- DMA_BYTES, 8, DMA transfers per active line.
- FIRST_ACTIVE_LINE, 80, first display line.
- ACTIVE_LINES, 128, display lines per frame. Must be a multiple of 8.
- INT_LEAD, 2, lines of INT before FIRST_ACTIVE_LINE.
- EF_LEAD, 4, lines of EFx low at the start and end of the display window.
- ADDR_W, 10, framebuffer address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clk_enable  in  1  one-cycle machine-cycle strobe; all state advances only when high (except reset)
- SC  in  2  CPU state code; 2'b10 = DMA cycle
- disp_on  in  1  enable display (sampled on clk_enable)
- disp_off  in  1  disable display (sampled on clk_enable)
- line_repeat  in  2  00=1, 01=2, 10=4, 11=8 scan lines per fetched row
- base_addr  in  ADDR_W  framebuffer address of row 0
- data_in  in  8  CPU data bus during DMA
- DMAO  out  1  DMA-out request, active-low
- INT  out  1  interrupt request, active-high
- EFx  out  1  frame flag, active-low
- mem_addr  out  ADDR_W  framebuffer write address
- mem_data  out  8  framebuffer write data
- mem_wr_en  out  1  one-clk write strobe
- line_start  out  1  one-clk pulse on the clk_enable at which h_cnt wraps to 0
- frame_start  out  1  one-clk pulse on the clk_enable at which v_cnt wraps to 0

Behaviour:
- Reset (async, any time, including mid-DMA):
  - DMAO=1, INT=0, EFx=1, mem_wr_en=0, mem_addr=0, mem_data=0, line_start=0, frame_start=0.
  - enabled=0; h_cnt, v_cnt, addr_cnt, row_start, rep_cnt, xfer_cnt = 0.
- Horizontal counter: h_cnt counts 0..BYTES_PER_LINE-1 on clk_enable and wraps to 0. Each wrap increments v_cnt, which wraps at LINES_PER_FRAME-1.
- Enable control: on clk_enable, disp_off clears enabled and disp_on sets it. If both are high together, disp_off wins.
- Active line: v_cnt in [FIRST_ACTIVE_LINE, FIRST_ACTIVE_LINE+ACTIVE_LINES-1].
- Registered outputs, updated on clk_enable and valid from the following clk:
  - DMAO=0 iff enabled, active line, and h_cnt in [1, DMA_BYTES].
  - INT=1 iff enabled and v_cnt in [FIRST_ACTIVE_LINE-INT_LEAD, FIRST_ACTIVE_LINE-1].
  - EFx=0 iff v_cnt in [FIRST_ACTIVE_LINE-EF_LEAD, FIRST_ACTIVE_LINE-1] or in the last EF_LEAD active lines. EFx is independent of enabled.
- DMA transfer, on a clk_enable with SC==2'b10, enabled, active line and xfer_cnt<DMA_BYTES:
  - mem_wr_en=1 for exactly one clk; mem_addr=addr_cnt; mem_data=data_in.
  - Then addr_cnt and xfer_cnt each +1. addr_cnt wraps modulo 2^ADDR_W.
  - DMA cycles outside these conditions are ignored: no write, no counter change.
- End of active line (h_cnt wrap), in this order:
  - xfer_cnt<=0.
  - If rep_cnt < repeat-1: rep_cnt+1 and addr_cnt<=row_start, so the same row is refetched.
  - Else: rep_cnt<=0 and row_start<=addr_cnt.
- Frame start (v_cnt wraps to 0):
  - line_repeat is latched into rep_sel.
  - addr_cnt<=base_addr, row_start<=base_addr, rep_cnt<=0.
  - Changes to line_repeat or base_addr mid-frame have no effect until the next frame start.
- disp_off mid-line: DMAO returns to 1 on the next clk_enable and no further writes occur. Counters keep running.
- Latency: request to write is zero extra cycles; the write happens in the same clk as the qualifying clk_enable.

Optional Feature:
- Macro PIXIE_DMA_STATS_EN. When defined, the block adds:
  - Output dma_short (1). Set when an active line ends with 0<xfer_cnt<DMA_BYTES.
  - Output dma_frames (8). Counts frame starts with enabled=1; wraps at 255.
  - dma_short is sticky and cleared by reset or by disp_on.
- Without the macro, these ports and registers do not exist. Behaviour of every other port is otherwise identical.

Test Plan:
- Reset mid-frame: assert reset at v_cnt=100 -> all outputs at reset values immediately; after release, DMAO=1 until disp_on.
- disp_on, default params, SC=10 for 8 cycles per line, repeat=00 -> 1024 writes per frame; mem_addr runs base_addr..base_addr+1023; DMAO low at h_cnt 1..8 only.
- line_repeat=10 (4 lines/row), base_addr=0x100 -> each address 0x100..0x107 is written on 4 consecutive lines; final row_start=0x100+256 at frame end.
- INT/EF timing -> INT high for lines 78-79; EFx low for lines 76-79 and 204-207; with display disabled, INT stays 0 and EFx still toggles.
- Simultaneous disp_on and disp_off -> enabled=0; a 9th DMA cycle in one line -> no write, addr_cnt unchanged.
- Stats build: only 5 DMA cycles on one line -> dma_short=1 until disp_on; 3 enabled frames -> dma_frames=3.
